// File: rtl/map_table_pkg.sv
// Shared types and sizes for the register-rename map table.
// Tags are ROB indices widened by one bit; the all-zero tag means "in regfile".
package map_table_pkg;

   localparam int REG_SIZE    = 32;
   localparam int ROB_SIZE    = 16;
   localparam int ROB_IDX_LEN = $clog2(ROB_SIZE);
   localparam int TAG_W       = ROB_IDX_LEN + 1;
   localparam int REG_IDX_W   = $clog2(REG_SIZE);

   localparam logic [TAG_W-1:0] ZERO_TAG = '0;

   typedef logic [TAG_W-1:0]     tag_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      logic squash;
      tag_t rob_tail;
   } ROB_MT_PACKET;

   typedef struct packed {
      reg_idx_t rs1_dispatch;
      reg_idx_t rs2_dispatch;
   } RS_MT_PACKET;

   typedef struct packed {
      tag_t rs1_tag;
      tag_t rs2_tag;
      logic rs1_ready;
      logic rs2_ready;
   } MT_RS_PACKET;

   // ZERO_TAG is never live, so it must never match the CDB, even an X one.
   function automatic logic cdb_hit(input tag_t tag, input tag_t cdb_tag);
      return (tag != ZERO_TAG) && (tag == cdb_tag);
   endfunction

endpackage

// File: rtl/map_table_entry.sv
// One map-table slot: newest producer tag plus its ready bit.
// Flush beats dispatch, dispatch beats retire, retire beats CDB wakeup.
module map_table_entry
   import map_table_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic flush,
   input  logic dispatch_hit,
   input  tag_t rob_tail,
   input  logic retire_hit,
   input  tag_t cdb_tag,
   output tag_t tag,
   output logic ready
);

   // Slot update with fixed priority among the four sources.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag   <= ZERO_TAG;
         ready <= 1'b0;
      end else if (flush) begin
         tag   <= ZERO_TAG;
         ready <= 1'b0;
      end else if (dispatch_hit) begin
         tag   <= rob_tail;
         ready <= 1'b0;
      end else if (retire_hit) begin
         tag   <= ZERO_TAG;
         ready <= 1'b0;
      end else if (cdb_hit(tag, cdb_tag)) begin
         ready <= 1'b1;
      end
   end

endmodule

// File: rtl/map_table.sv
// Register-rename map table: one slot per architectural register.
// Reads are combinational, see pre-edge state, and bypass the live CDB tag.
module map_table
   import map_table_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  ROB_MT_PACKET rob_mt,
   input  logic         dispatch_enable,
   input  reg_idx_t     rd_dispatch,
   input  RS_MT_PACKET  rs_mt,
   input  tag_t         CDB_tag,
   input  logic         clear,
   input  reg_idx_t     rd_retire,
   output MT_RS_PACKET  mt_rs
);

   tag_t tag_q   [REG_SIZE];
   logic ready_q [REG_SIZE];

   genvar i;
   generate
      for (i = 0; i < REG_SIZE; i++) begin : g_entry
         logic dispatch_hit;
         logic retire_hit;

         // Register 0 is hardwired, so it can never be renamed.
         assign dispatch_hit = (i != 0) && dispatch_enable
                               && (rd_dispatch == reg_idx_t'(i));
         assign retire_hit   = clear && (rd_retire == reg_idx_t'(i));

         map_table_entry u_entry (
            .clock        (clock),
            .reset        (reset),
            .flush        (rob_mt.squash),
            .dispatch_hit (dispatch_hit),
            .rob_tail     (rob_mt.rob_tail),
            .retire_hit   (retire_hit),
            .cdb_tag      (CDB_tag),
            .tag          (tag_q[i]),
            .ready        (ready_q[i])
         );
      end
   endgenerate

   tag_t rs1_tag;
   tag_t rs2_tag;

   // Source operand lookups with same-cycle CDB wakeup bypass.
   always_comb begin
      rs1_tag         = tag_q[rs_mt.rs1_dispatch];
      rs2_tag         = tag_q[rs_mt.rs2_dispatch];
      mt_rs.rs1_tag   = rs1_tag;
      mt_rs.rs2_tag   = rs2_tag;
      mt_rs.rs1_ready = ready_q[rs_mt.rs1_dispatch]
                        | cdb_hit(rs1_tag, CDB_tag);
      mt_rs.rs2_ready = ready_q[rs_mt.rs2_dispatch]
                        | cdb_hit(rs2_tag, CDB_tag);
   end

endmodule

// File: tb/tb_map_table.sv
// Self-checking bench for map_table: directed scenarios then random traffic.
// Expected values come from a per-register array model of the rename rules.
module tb_map_table;
   import map_table_pkg::*;

   logic         clock;
   logic         reset;
   ROB_MT_PACKET rob_mt;
   logic         dispatch_enable;
   reg_idx_t     rd_dispatch;
   RS_MT_PACKET  rs_mt;
   tag_t         CDB_tag;
   logic         clear;
   reg_idx_t     rd_retire;
   MT_RS_PACKET  mt_rs;

   int n_assert = 0;
   int n_fail   = 0;

   tag_t m_tag [REG_SIZE];
   bit   m_rdy [REG_SIZE];

   map_table dut (
      .clock           (clock),
      .reset           (reset),
      .rob_mt          (rob_mt),
      .dispatch_enable (dispatch_enable),
      .rd_dispatch     (rd_dispatch),
      .rs_mt           (rs_mt),
      .CDB_tag         (CDB_tag),
      .clear           (clear),
      .rd_retire       (rd_retire),
      .mt_rs           (mt_rs)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < REG_SIZE; k++) begin
         m_tag[k] = '0;
         m_rdy[k] = 1'b0;
      end
   endtask

   function automatic bit m_read_rdy(input int r, input tag_t cdb);
      return m_rdy[r] || (m_tag[r] != 0 && m_tag[r] == cdb);
   endfunction

   task automatic idle();
      rob_mt          = '0;
      dispatch_enable = 1'b0;
      rd_dispatch     = '0;
      clear           = 1'b0;
      rd_retire       = '0;
      CDB_tag         = '0;
   endtask

   // One clock: drive, check both reads before the edge, advance model.
   task automatic step(input bit sq, input tag_t tail, input bit de,
                       input int rd, input int r1, input int r2,
                       input tag_t cdb, input bit clr, input int rr);
      tag_t nt [REG_SIZE];
      bit   nr [REG_SIZE];
      rob_mt.squash     = sq;
      rob_mt.rob_tail   = tail;
      dispatch_enable   = de;
      rd_dispatch       = reg_idx_t'(rd);
      rs_mt.rs1_dispatch = reg_idx_t'(r1);
      rs_mt.rs2_dispatch = reg_idx_t'(r2);
      CDB_tag           = cdb;
      clear             = clr;
      rd_retire         = reg_idx_t'(rr);
      #1;
      chk("rs1_tag", mt_rs.rs1_tag, m_tag[r1]);
      chk("rs2_tag", mt_rs.rs2_tag, m_tag[r2]);
      chk("rs1_ready", mt_rs.rs1_ready, m_read_rdy(r1, cdb));
      chk("rs2_ready", mt_rs.rs2_ready, m_read_rdy(r2, cdb));
      for (int k = 0; k < REG_SIZE; k++) begin
         nt[k] = m_tag[k];
         nr[k] = m_rdy[k];
         if (sq) begin
            nt[k] = '0; nr[k] = 1'b0;
         end else if (de && rd == k && k != 0) begin
            nt[k] = tail; nr[k] = 1'b0;
         end else if (clr && rr == k) begin
            nt[k] = '0; nr[k] = 1'b0;
         end else if (m_tag[k] != 0 && m_tag[k] == cdb) begin
            nr[k] = 1'b1;
         end
      end
      @(posedge clock);
      for (int k = 0; k < REG_SIZE; k++) begin
         m_tag[k] = nt[k];
         m_rdy[k] = nr[k];
      end
      #1;
      idle();
   endtask

   // Read one register with no CDB activity and compare to constants.
   task automatic expect_reg(input int r, input tag_t t, input bit rdy);
      rs_mt.rs1_dispatch = reg_idx_t'(r);
      CDB_tag = '0;
      #1;
      chk($sformatf("reg%0d_tag", r), mt_rs.rs1_tag, t);
      chk($sformatf("reg%0d_ready", r), mt_rs.rs1_ready, rdy);
   endtask

   // Compare every entry to the model; inputs are idle so edges hold state.
   task automatic sweep(input string name);
      idle();
      for (int r = 0; r < REG_SIZE; r++) begin
         rs_mt.rs1_dispatch = reg_idx_t'(r);
         rs_mt.rs2_dispatch = reg_idx_t'(REG_SIZE - 1 - r);
         #1;
         chk({name, "_tag"}, mt_rs.rs1_tag, m_tag[r]);
         chk({name, "_rdy"}, mt_rs.rs1_ready, m_rdy[r]);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      rs_mt = '0;
      model_clear();
      #12;
      sweep("reset");
      reset = 1'b0;

      step(0, 5'd1, 1, 15, 0, 0, 5'd0, 0, 0);
      step(0, 5'd2, 0, 11, 15, 11, 5'd0, 0, 0);
      expect_reg(15, 5'd1, 1'b0);
      expect_reg(11, 5'd0, 1'b0);
      sweep("disp_off");
      step(0, 5'd2, 1, 11, 0, 0, 5'd0, 0, 0);
      expect_reg(11, 5'd2, 1'b0);

      step(0, 5'd3, 1, 31, 0, 0, 5'd0, 0, 0);
      step(0, 5'd4, 1, 7, 0, 0, 5'd0, 0, 0);
      rs_mt.rs2_dispatch = 5'd11;
      CDB_tag = 5'd2;
      #1;
      chk("bypass_tag", mt_rs.rs2_tag, 5'd2);
      chk("bypass_rdy", mt_rs.rs2_ready, 1'b1);
      step(0, 5'd0, 0, 0, 7, 11, 5'd2, 0, 0);
      expect_reg(11, 5'd2, 1'b1);
      step(0, 5'd0, 0, 0, 31, 11, 5'd3, 0, 0);
      expect_reg(31, 5'd3, 1'b1);
      step(0, 5'd0, 0, 0, 7, 0, 5'd5, 0, 0);
      expect_reg(7, 5'd4, 1'b0);

      step(0, 5'd0, 0, 0, 31, 11, 5'd0, 1, 31);
      expect_reg(31, 5'd0, 1'b0);
      expect_reg(11, 5'd2, 1'b1);
      step(0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 31);
      expect_reg(7, 5'd4, 1'b0);
      expect_reg(15, 5'd1, 1'b0);
      sweep("hold");
      step(0, 5'd0, 0, 0, 11, 0, 5'd0, 1, 11);
      expect_reg(11, 5'd0, 1'b0);

      step(1, 5'd9, 1, 3, 7, 15, 5'd4, 1, 7);
      sweep("squash");

      step(0, 5'd6, 1, 9, 9, 0, 5'd0, 1, 9);
      expect_reg(9, 5'd6, 1'b0);
      step(0, 5'd7, 1, 0, 0, 9, 5'd0, 0, 0);
      expect_reg(0, 5'd0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         bit   sq;
         tag_t tail;
         tag_t cdb;
         sq   = ($urandom_range(0, 39) == 0);
         tail = tag_t'($urandom_range(1, (1 << TAG_W) - 1));
         if ($urandom_range(0, 1) == 1)
            cdb = m_tag[$urandom_range(0, REG_SIZE - 1)];
         else
            cdb = tag_t'($urandom_range(0, (1 << TAG_W) - 1));
         step(sq, tail, ($urandom_range(0, 9) < 6),
              $urandom_range(0, REG_SIZE - 1),
              $urandom_range(0, REG_SIZE - 1),
              $urandom_range(0, REG_SIZE - 1), cdb,
              ($urandom_range(0, 9) < 3), $urandom_range(0, REG_SIZE - 1));
         if (n % 100 == 99) sweep("random");
      end

      #2;
      reset = 1'b1;
      model_clear();
      #1;
      expect_reg(7, 5'd0, 1'b0);
      sweep("async_reset");
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
